// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a same-domain divided clock in clk_in cycles.
// Outputs update one cycle after each rise; locks after LOCK_CNT identical periods.
module clk_ratio_meter #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_M  = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic             sig_q;
  logic [CNT_W-1:0] cnt, cnt_nxt, hcnt, hcnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic [3:0]       match, match_nxt;
  logic             first_meas, first_nxt;
  logic             valid_nxt, locked_nxt, ovf_nxt;
  logic             rise;

  assign rise = sig_in & ~sig_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sig_q        <= 1'b0;
      cnt          <= '0;
      hcnt         <= '0;
      match        <= '0;
      first_meas   <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      sig_q        <= sig_in;
      cnt          <= cnt_nxt;
      hcnt         <= hcnt_nxt;
      match        <= match_nxt;
      first_meas   <= first_nxt;
      period       <= period_nxt;
      high_time    <= high_nxt;
      period_valid <= valid_nxt;
      locked       <= locked_nxt;
      overflow     <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hcnt_nxt   = hcnt;
    match_nxt  = match;
    first_nxt  = first_meas;
    period_nxt = period;
    high_nxt   = high_time;
    valid_nxt  = 1'b0;
    locked_nxt = locked;
    ovf_nxt    = overflow;
    if (!enable) begin
      // Disable outranks rise and overflow; measured values are kept.
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      hcnt_nxt   = '0;
      match_nxt  = '0;
      locked_nxt = 1'b0;
      ovf_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: state_nxt = WAIT_EDGE;
        WAIT_EDGE: begin
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            hcnt_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
            first_nxt = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt = cnt;
            high_nxt   = hcnt;
            valid_nxt  = 1'b1;
            cnt_nxt    = {{(CNT_W-1){1'b0}}, 1'b1};
            hcnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            first_nxt  = 1'b0;
            // The stored period is only a valid reference after the first measurement.
            if (first_meas || (cnt != period)) begin
              match_nxt = 4'd1;
            end else if (match < LOCK_M) begin
              match_nxt = match + 4'd1;
            end
            locked_nxt = (match_nxt == LOCK_M);
          end else if (cnt == CNT_MAX) begin
            state_nxt  = WAIT_EDGE;
            cnt_nxt    = '0;
            hcnt_nxt   = '0;
            match_nxt  = '0;
            locked_nxt = 1'b0;
            ovf_nxt    = 1'b1;
          end else begin
            cnt_nxt  = cnt + 1'b1;
            hcnt_nxt = hcnt + {{(CNT_W-1){1'b0}}, sig_in};
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
Measures a divided clock, such as a clk_div_2/4/8/16 output of the clock divider, by sampling it as data in the clk_in domain. Reports the period and the high time, both in clk_in cycles. Asserts a lock flag once the period is stable. Used as the checking end of the divider chain, on hardware and in self-checking benches.

Parameters:
CNT_W, 8, width of the period/high-time counters and outputs; max measurable period is 2^CNT_W-1.
LOCK_CNT, 4, number of consecutive identical period measurements required to assert locked (range 2..15).

Ports:
clk_in  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset; clears all state immediately.
enable  input  1  measurement enable; low forces IDLE.
sig_in  input  1  signal under measurement; must be driven from a clk_in-domain register.
period  output  CNT_W  last measured period in clk_in cycles.
high_time  output  CNT_W  clk_in cycles sig_in was high within that period.
period_valid  output  1  one-cycle pulse when period/high_time update.
locked  output  1  high while the last LOCK_CNT periods were identical.
overflow  output  1  sticky; a period reached 2^CNT_W-1 without a rising edge.

Behaviour:
- Reset (rst=0): state=IDLE, sig_q=0, cnt=0, hcnt=0, match=0; period=0, high_time=0, period_valid=0, locked=0, overflow=0.
- Edge detect: sig_q is sig_in registered once. rise = sig_in & ~sig_q. No synchronizer; sig_in is same-domain.
- FSM states: IDLE, WAIT_EDGE, MEASURE.
  - IDLE: entered whenever enable=0, from any state, with priority over every other event. cnt, hcnt and match are cleared; locked=0 and overflow=0. period/high_time hold their values. enable=1 -> WAIT_EDGE.
  - WAIT_EDGE: on rise -> MEASURE with cnt=1 and hcnt=1. No output update.
  - MEASURE, each cycle without rise: cnt+=1; hcnt+=1 if sig_in=1.
  - MEASURE, cycle with rise: period<=cnt, high_time<=hcnt, period_valid=1 in the next cycle; then cnt=1, hcnt=1, stay in MEASURE.
- Resulting values: a 50% divide-by-N input gives period=N and high_time=N/2. Outputs become valid one cycle after the rise cycle.
- Lock counter update, on each measurement:
  - First measurement after WAIT_EDGE: match=1.
  - Later measurements: if the new period equals the stored period, match=min(match+1, LOCK_CNT); otherwise match=1.
  - locked = (match==LOCK_CNT), registered. It is first high in the same cycle as the LOCK_CNT-th period_valid pulse.
  - A mismatching period drops locked in the same cycle as that pulse.
- Overflow: in MEASURE, if cnt==2^CNT_W-1 and there is no rise:
  - overflow<=1 (sticky until reset or enable=0), locked<=0, match<=0, state -> WAIT_EDGE.
  - period/high_time hold; no period_valid pulse.
- A constant 0 or constant 1 on sig_in after the first edge therefore overflows. A constant level before the first edge stays in WAIT_EDGE indefinitely.
- Simultaneous events:
  - enable falling in a rise cycle: IDLE wins, no update.
  - rise in the same cycle cnt hits max: the measurement wins, no overflow.
- Reset asserted mid-measurement: all outputs return to reset values asynchronously. After release, measurement restarts from WAIT_EDGE once enable=1. The first post-reset edge produces no period_valid.
- Counter arithmetic is unsigned CNT_W. hcnt never exceeds cnt, so it cannot wrap independently.

Test Plan:
1. sig_in=clk_div_2 from the divider, enable=1 after the divider reset releases -> period_valid every 2 cycles, period=2, high_time=1; locked high on the 4th pulse.
2. sig_in=clk_div_16 -> period=16, high_time=8, period_valid every 16 cycles; locked after the 4th pulse, i.e. 64 clk_in cycles after the first rise.
3. While locked on clk_div_4, switch the mux to clk_div_8 -> one transitional measurement, locked drops; then period=8, high_time=4; locked reasserts after 4 identical periods.
4. CNT_W=4, sig_in pulses once then holds 0 -> overflow=1 after 15 cycles, locked=0, state WAIT_EDGE; a later clk_div_4 input measures period=4 with overflow still 1; enable low for 1 cycle -> overflow=0.
5. Deassert enable exactly in a rise cycle -> no period_valid, locked=0, period holds its prior value; re-enable -> first update one full period after the next rise.
6. Pull rst low mid-period while locked on clk_div_8 -> period=0, high_time=0, locked=0 immediately, without waiting for a clk_in edge; after release, the first period_valid reports 8.
